midi_interface: RTL and testbench

//   MIDI input front end. It receives a serial MIDI stream (UART 8N1) on uart_rx and

---
 rtl/midi_interface.sv | 225 ++++++++++++++++++++++
 tb/tb_midi_interface.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_interface.sv
`default_nettype none
// ============================================================================
//  Module      : midi_interface
//  Description : MIDI input front end. A UART 8N1 receiver feeds a Note On /
//                Note Off parser that keeps running status. The parser emits
//                one-cycle note events and the receiver exposes raw bytes for
//                debug.
//  Revision    : 1.0 - initial release
// ============================================================================
module midi_interface #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] midi_note,
    output logic       note_on,
    output logic       note_off,
    output logic [7:0] debug_uart_byte,
    output logic       debug_uart_ready
);

    localparam int c_BIT_TICKS  = CLOCK_FREQ / BAUD_RATE;
    localparam int c_HALF_TICKS = c_BIT_TICKS / 2;
    localparam int c_CNT_W      = $clog2(c_BIT_TICKS + 1);

    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_BIT_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF_TICKS - 1);

    // Receiver states
    localparam logic [1:0] c_RX_IDLE  = 2'd0;
    localparam logic [1:0] c_RX_START = 2'd1;
    localparam logic [1:0] c_RX_DATA  = 2'd2;
    localparam logic [1:0] c_RX_STOP  = 2'd3;

    // Parser states
    localparam logic [1:0] c_P_WAIT_STATUS = 2'd0;
    localparam logic [1:0] c_P_WAIT_NOTE   = 2'd1;
    localparam logic [1:0] c_P_WAIT_VEL    = 2'd2;

    // ------------------------------------------------------------------
    // Receiver signals
    // ------------------------------------------------------------------
    logic               rx_meta_q, rx_sync_q;
    logic [1:0]         rx_state_q, rx_state_d;
    logic [c_CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               wait_high_q, wait_high_d;
    logic [7:0]         byte_q, byte_d;
    logic               ready_q, ready_d;

    logic w_tick_done;
    logic w_half_done;

    assign w_tick_done = (tick_cnt_q == c_BIT_LAST);
    assign w_half_done = (tick_cnt_q == c_HALF_LAST);

    // Two-flop synchroniser on the asynchronous serial line; idles high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state_q  <= c_RX_IDLE;
            tick_cnt_q  <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            wait_high_q <= 1'b0;
            byte_q      <= 8'h00;
            ready_q     <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            wait_high_q <= wait_high_d;
            byte_q      <= byte_d;
            ready_q     <= ready_d;
        end
    end

    // Receiver next-state: start bit qualified at half-bit, 8 data bits, stop bit.
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            c_RX_IDLE:  if (!wait_high_q && !rx_sync_q) rx_state_d = c_RX_START;
            c_RX_START: if (w_half_done) rx_state_d = rx_sync_q ? c_RX_IDLE : c_RX_DATA;
            c_RX_DATA:  if (w_tick_done && (bit_idx_q == 3'd7)) rx_state_d = c_RX_STOP;
            c_RX_STOP:  if (w_tick_done) rx_state_d = c_RX_IDLE;
            default:    rx_state_d = c_RX_IDLE;
        endcase
    end

    // Receiver datapath: tick counting, LSB-first shifting, stop-bit check.
    always_comb begin
        tick_cnt_d  = tick_cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        wait_high_d = wait_high_q;
        byte_d      = byte_q;
        ready_d     = 1'b0;
        case (rx_state_q)
            c_RX_IDLE: begin
                tick_cnt_d = '0;
                bit_idx_d  = 3'd0;
                // After a framing error the line must return high before a new start.
                if (rx_sync_q) wait_high_d = 1'b0;
            end
            c_RX_START: begin
                if (w_half_done) tick_cnt_d = '0;
            end
            c_RX_DATA: begin
                if (w_tick_done) begin
                    tick_cnt_d = '0;
                    shift_d    = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                end
            end
            c_RX_STOP: begin
                if (w_tick_done) begin
                    tick_cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_d  = shift_q;
                        ready_d = 1'b1;
                    end else begin
                        wait_high_d = 1'b1;
                    end
                end
            end
            default: tick_cnt_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // MIDI parser
    // ------------------------------------------------------------------
    logic [1:0] p_state_q, p_state_d;
    logic       is_on_q, is_on_d;
    logic [6:0] note_q, note_d;
    logic [7:0] midi_note_q, midi_note_d;
    logic       note_on_q, note_on_d;
    logic       note_off_q, note_off_d;

    logic w_is_status;
    logic w_is_realtime;
    logic w_is_note_status;

    assign w_is_status      = byte_q[7];
    assign w_is_realtime    = (byte_q[7:3] == 5'b11111);
    assign w_is_note_status = (byte_q[7:4] == 4'h8) || (byte_q[7:4] == 4'h9);

    // Parser state and event registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            p_state_q   <= c_P_WAIT_STATUS;
            is_on_q     <= 1'b0;
            note_q      <= 7'd0;
            midi_note_q <= 8'h00;
            note_on_q   <= 1'b0;
            note_off_q  <= 1'b0;
        end else begin
            p_state_q   <= p_state_d;
            is_on_q     <= is_on_d;
            note_q      <= note_d;
            midi_note_q <= midi_note_d;
            note_on_q   <= note_on_d;
            note_off_q  <= note_off_d;
        end
    end

    // Parser next-state; realtime bytes leave state and running status untouched.
    always_comb begin
        p_state_d = p_state_q;
        if (ready_q) begin
            if (w_is_status) begin
                if (w_is_note_status)   p_state_d = c_P_WAIT_NOTE;
                else if (!w_is_realtime) p_state_d = c_P_WAIT_STATUS;
            end else begin
                case (p_state_q)
                    c_P_WAIT_NOTE: p_state_d = c_P_WAIT_VEL;
                    c_P_WAIT_VEL:  p_state_d = c_P_WAIT_NOTE;
                    default:       p_state_d = c_P_WAIT_STATUS;
                endcase
            end
        end
    end

    // Parser outputs: latch message type and note, emit the event on velocity.
    always_comb begin
        is_on_d     = is_on_q;
        note_d      = note_q;
        midi_note_d = midi_note_q;
        note_on_d   = 1'b0;
        note_off_d  = 1'b0;
        if (ready_q) begin
            if (w_is_status) begin
                if (w_is_note_status) is_on_d = byte_q[4];
            end else if (p_state_q == c_P_WAIT_NOTE) begin
                note_d = byte_q[6:0];
            end else if (p_state_q == c_P_WAIT_VEL) begin
                midi_note_d = {1'b0, note_q};
                if (is_on_q && (byte_q[6:0] != 7'd0)) note_on_d  = 1'b1;
                else                                  note_off_d = 1'b1;
            end
        end
    end

    assign midi_note        = midi_note_q;
    assign note_on          = note_on_q;
    assign note_off         = note_off_q;
    assign debug_uart_byte  = byte_q;
    assign debug_uart_ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_interface.sv
`default_nettype none
// ============================================================================
//  Module      : tb_midi_interface
//  Description : Scoreboard bench for midi_interface. Stimulus pushes expected
//                bytes/events from a byte-stream reference model; a monitor
//                pops and compares whenever the DUT pulses an output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_interface;

    localparam int c_CLOCK_FREQ = 1_000_000;
    localparam int c_BAUD_RATE  = 62_500;
    localparam int c_BIT        = c_CLOCK_FREQ / c_BAUD_RATE;

    typedef struct {
        bit         on;
        logic [7:0] note;
    } evt_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] midi_note;
    logic       note_on;
    logic       note_off;
    logic [7:0] debug_uart_byte;
    logic       debug_uart_ready;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_rdy = -10;

    logic [7:0] exp_bytes[$];
    evt_t       exp_evts[$];

    // Reference model state: running status byte (0 = none) and pending data bytes
    logic [7:0] rs = 8'h00;
    logic [7:0] pend[$];
    logic [7:0] last_byte = 8'h00;
    logic [7:0] last_note = 8'h00;

    midi_interface #(
        .CLOCK_FREQ(c_CLOCK_FREQ),
        .BAUD_RATE (c_BAUD_RATE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .uart_rx         (uart_rx),
        .midi_note       (midi_note),
        .note_on         (note_on),
        .note_off        (note_off),
        .debug_uart_byte (debug_uart_byte),
        .debug_uart_ready(debug_uart_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: MIDI byte stream -> expected bytes and note events
    task automatic model_byte(input logic [7:0] b);
        evt_t e;
        exp_bytes.push_back(b);
        last_byte = b;
        if (b >= 8'hF8) return;
        if (b[7]) begin
            pend.delete();
            rs = ((b >> 4) == 8'h8 || (b >> 4) == 8'h9) ? b : 8'h00;
        end else if (rs != 8'h00) begin
            pend.push_back(b);
            if (pend.size() == 2) begin
                e.on   = ((rs >> 4) == 8'h9) && (pend[1] != 8'h00);
                e.note = pend[0];
                exp_evts.push_back(e);
                last_note = pend[0];
                pend.delete();
            end
        end
    endtask

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (c_BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        uart_rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 1'b1);
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        reset   = 1'b0;
        uart_rx = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (check) begin
                chk("rst_midi_note", midi_note, 0);
                chk("rst_note_on", note_on, 0);
                chk("rst_note_off", note_off, 0);
                chk("rst_uart_byte", debug_uart_byte, 0);
                chk("rst_uart_ready", debug_uart_ready, 0);
            end
        end
        reset = 1'b1;
        rs = 8'h00;
        pend.delete();
        last_byte = 8'h00;
        last_note = 8'h00;
    endtask

    // Monitor: compare every DUT pulse against the head of the matching queue
    always @(negedge clk) begin
        evt_t e;
        cyc = cyc + 1;
        if (reset) begin
            if (debug_uart_ready) begin
                last_rdy = cyc;
                if (exp_bytes.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got 0x%0h expected no byte", debug_uart_byte);
                end else begin
                    chk("uart_byte", debug_uart_byte, exp_bytes.pop_front());
                end
            end
            if (note_on || note_off) begin
                chk("pulse_exclusive", note_on & note_off, 0);
                chk("event_latency", cyc - last_rdy, 1);
                if (exp_evts.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got on=%0d off=%0d note=0x%0h expected no event",
                             note_on, note_off, midi_note);
                end else begin
                    e = exp_evts.pop_front();
                    chk("event_kind_on", note_on, e.on);
                    chk("midi_note", midi_note, e.note);
                end
            end
        end
    end

    // Safety net against a stuck run
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int r;

        // 1. reset with idle line
        do_reset(1'b1);
        idle(50);
        chk("idle_no_pending", exp_bytes.size(), 0);

        // 2. Note On
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h7F);
        idle(20);
        chk("note_hold_t2", midi_note, 8'h3C);

        // 3. Note Off
        send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00);
        idle(20);

        // 4. Note On velocity 0, then running status
        send_byte(8'h91); send_byte(8'h40); send_byte(8'h00);
        send_byte(8'h45); send_byte(8'h64);
        idle(20);
        chk("note_hold_t4", midi_note, 8'h45);

        // 5. realtime interleaved, then aborted message
        send_byte(8'h90); send_byte(8'hF8); send_byte(8'h3C); send_byte(8'h7F);
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hB0);
        idle(20);
        chk("byte_hold_t5", debug_uart_byte, 8'hB0);

        // 6a. framing error: no byte, then a good message
        send_frame(8'h55, 1'b0);
        idle(2 * c_BIT);
        send_byte(8'h90); send_byte(8'h22); send_byte(8'h11);
        idle(20);

        // 6b. short glitch on the line
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        idle(3 * c_BIT);
        chk("glitch_byte_hold", debug_uart_byte, 8'h11);

        // 6c. reset mid-byte after a partial message
        send_byte(8'h90); send_byte(8'h3C);
        idle(10);
        chk("drained_before_reset", exp_bytes.size(), 0);
        uart_rx = 1'b0;
        repeat (c_BIT) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * c_BIT) @(negedge clk);
        do_reset(1'b0);
        idle(2 * c_BIT);
        chk("post_reset_note", midi_note, 0);
        chk("post_reset_byte", debug_uart_byte, 0);
        send_byte(8'h7F);
        send_byte(8'h90); send_byte(8'h40); send_byte(8'h50);
        idle(20);

        // Randomised stream
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    b = 8'h80 | 8'($urandom_range(0, 31));
                2:       b = 8'hF8 + 8'($urandom_range(0, 7));
                3:       b = 8'hA0 + 8'($urandom_range(0, 8'h57));
                4:       b = 8'h00;
                default: b = 8'($urandom_range(0, 127));
            endcase
            send_byte(b);
            idle($urandom_range(0, 30));
        end
        idle(50);
        chk("final_note", midi_note, last_note);
        chk("final_byte", debug_uart_byte, last_byte);
        chk("bytes_drained", exp_bytes.size(), 0);
        chk("events_drained", exp_evts.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
